rlc_dec_arbiter: RTL and testbench

Shares one RLC decoder (4-bit value + 3-bit run tokens in, packed 8-nibble 32-bit words out) among N requesting streams. A requester is granted the decoder for one job. Its input words are forwarded to the decoder and the decoded words are returned tagged with its ID. The job ends when the declared number of output words has been delivered. The decoder is then flushed so that leftover bits never leak into the next job. The block sits between the stream sources and the decoder instance, and owns the decoder's synchronous flush.

---
 rtl/rlc_dec_arbiter_if.sv | 42 ++++
 rtl/rlc_dec_arbiter.sv | 170 +++++++++++++++++
 tb/tb_rlc_dec_arbiter.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rlc_dec_arbiter_if.sv
// Bundle of requester, decoder and consumer signals around the shared RLC decoder arbiter.
// The arbiter takes the master view; the surrounding environment takes the slave view.
interface rlc_dec_arbiter_if #(
    parameter int unsigned N    = 4,
    parameter int unsigned IDW  = $clog2(N),
    parameter int unsigned LENW = 16
);
    logic [N-1:0]      req_valid;
    logic [32*N-1:0]   req_data;
    logic [LENW*N-1:0] req_len;
    logic [N-1:0]      req_ready;
    logic [N-1:0]      req_done;

    logic [31:0]       dec_in_data;
    logic              dec_in_valid;
    logic              dec_in_ready;
    logic [31:0]       dec_out;
    logic              dec_out_valid;
    logic              dec_out_ready;
    logic              dec_rst;

    logic [31:0]       out_data;
    logic              out_valid;
    logic              out_ready;
    logic [IDW-1:0]    out_id;

    logic              busy;
    logic              err;
    logic [IDW-1:0]    err_id;

    modport master (
        input  req_valid, req_data, req_len, dec_in_ready, dec_out, dec_out_valid, out_ready,
        output req_ready, req_done, dec_in_data, dec_in_valid, dec_out_ready, dec_rst,
               out_data, out_valid, out_id, busy, err, err_id
    );

    modport slave (
        output req_valid, req_data, req_len, dec_in_ready, dec_out, dec_out_valid, out_ready,
        input  req_ready, req_done, dec_in_data, dec_in_valid, dec_out_ready, dec_rst,
               out_data, out_valid, out_id, busy, err, err_id
    );
endinterface

// File: rtl/rlc_dec_arbiter.sv
// Round-robin arbiter granting one shared RLC decoder to N streams, one job at a time.
// Each job ends after its declared output word count (or a timeout) and is followed by a flush.
module rlc_dec_arbiter #(
    parameter int unsigned N         = 4,
    parameter int unsigned IDW       = $clog2(N),
    parameter int unsigned LENW      = 16,
    parameter int unsigned TIMEOUT   = 1024,
    parameter int unsigned FLUSH_CYC = 2
) (
    input logic               clk,
    input logic               reset_n,
    rlc_dec_arbiter_if.master bus
);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam int unsigned FW = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

    typedef enum logic [1:0] {StFlush, StIdle, StRun} state_e;

    state_e          state_q, state_d;
    logic [FW-1:0]   fcnt_q, fcnt_d;
    logic [IDW-1:0]  gid_q, gid_d;
    logic [IDW-1:0]  rr_q, rr_d;
    logic [IDW-1:0]  err_id_q, err_id_d;
    logic [LENW-1:0] len_q, len_d;
    logic [LENW-1:0] cnt_q, cnt_d;
    logic [TW-1:0]   idle_q, idle_d;
    logic            done_q, done_d;
    logic            err_q, err_d;

    logic            any_req;
    logic [IDW-1:0]  pick;
    logic [IDW-1:0]  cand;
    logic [LENW-1:0] pick_len;
    logic            in_hs, out_hs;

    logic [N-1:0]    req_ready_c;
    logic [31:0]     dec_in_data_c;
    logic            dec_in_valid_c;
    logic            dec_out_ready_c;
    logic            dec_rst_c;
    logic [31:0]     out_data_c;
    logic            out_valid_c;

    // Round-robin search starting at rr_q, wrapping modulo N.
    always_comb begin
        any_req = 1'b0;
        pick    = '0;
        cand    = '0;
        for (int unsigned i = 0; i < N; i++) begin
            cand = IDW'((32'(rr_q) + i) % N);
            if (!any_req && bus.req_valid[cand]) begin
                any_req = 1'b1;
                pick    = cand;
            end
        end
    end

    assign pick_len = bus.req_len[LENW*32'(pick) +: LENW];
    assign in_hs    = bus.req_valid[gid_q] & bus.dec_in_ready;
    assign out_hs   = bus.dec_out_valid & bus.out_ready;

    always_comb begin
        state_d  = state_q;
        fcnt_d   = fcnt_q;
        gid_d    = gid_q;
        rr_d     = rr_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        idle_d   = idle_q;
        err_id_d = err_id_q;
        done_d   = 1'b0;
        err_d    = 1'b0;

        req_ready_c     = '0;
        dec_in_data_c   = '0;
        dec_in_valid_c  = 1'b0;
        dec_out_ready_c = 1'b0;
        dec_rst_c       = 1'b0;
        out_data_c      = '0;
        out_valid_c     = 1'b0;

        unique case (state_q)
            StFlush: begin
                dec_rst_c       = 1'b1;
                dec_out_ready_c = 1'b1;
                if (fcnt_q == FW'(FLUSH_CYC - 1)) begin
                    fcnt_d  = '0;
                    state_d = StIdle;
                end else begin
                    fcnt_d = fcnt_q + FW'(1);
                end
            end
            StIdle: begin
                if (any_req) begin
                    gid_d  = pick;
                    len_d  = pick_len;
                    cnt_d  = '0;
                    idle_d = '0;
                    rr_d   = (32'(pick) == N - 1) ? '0 : pick + IDW'(1);
                    if (pick_len == '0) begin
                        state_d = StFlush;
                        done_d  = 1'b1;
                    end else begin
                        state_d = StRun;
                    end
                end
            end
            StRun: begin
                req_ready_c[gid_q] = bus.dec_in_ready;
                dec_in_data_c      = bus.req_data[32*32'(gid_q) +: 32];
                dec_in_valid_c     = bus.req_valid[gid_q];
                dec_out_ready_c    = bus.out_ready;
                out_data_c         = bus.dec_out;
                out_valid_c        = bus.dec_out_valid;
                if (out_hs) cnt_d = cnt_q + LENW'(1);
                idle_d = (in_hs || out_hs) ? '0 : idle_q + TW'(1);
                // Completion wins over a coincident timeout: a handshake clears the idle count.
                if (out_hs && (cnt_q + LENW'(1) == len_q)) begin
                    state_d = StFlush;
                    done_d  = 1'b1;
                end else if (!in_hs && !out_hs && idle_q == TW'(TIMEOUT - 1)) begin
                    state_d  = StFlush;
                    err_d    = 1'b1;
                    err_id_d = gid_q;
                end
            end
            default: state_d = StFlush;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StFlush;
            fcnt_q   <= '0;
            gid_q    <= '0;
            rr_q     <= '0;
            len_q    <= '0;
            cnt_q    <= '0;
            idle_q   <= '0;
            err_id_q <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            fcnt_q   <= fcnt_d;
            gid_q    <= gid_d;
            rr_q     <= rr_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            idle_q   <= idle_d;
            err_id_q <= err_id_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    // gid_q is stable through the flush, so it still names the finished job.
    assign bus.req_done      = done_q ? (N'(1) << gid_q) : '0;
    assign bus.req_ready     = req_ready_c;
    assign bus.dec_in_data   = dec_in_data_c;
    assign bus.dec_in_valid  = dec_in_valid_c;
    assign bus.dec_out_ready = dec_out_ready_c;
    assign bus.dec_rst       = dec_rst_c;
    assign bus.out_data      = out_data_c;
    assign bus.out_valid     = out_valid_c;
    assign bus.out_id        = gid_q;
    assign bus.busy          = (state_q != StIdle);
    assign bus.err           = err_q;
    assign bus.err_id        = err_id_q;
endmodule

// File: tb/tb_rlc_dec_arbiter.sv
// Scenario bench for rlc_dec_arbiter: the bench plays requesters, decoder and consumer,
// and predicts grants with a round-robin reference model.
module tb_rlc_dec_arbiter;
    localparam int N         = 4;
    localparam int IDW       = 2;
    localparam int LENW      = 16;
    localparam int TIMEOUT   = 16;
    localparam int FLUSH_CYC = 2;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int vectors = 0;
    int errors = 0;
    int model_rr = 0;
    logic [31:0] words[N];

    rlc_dec_arbiter_if #(.N(N), .IDW(IDW), .LENW(LENW)) bus ();

    rlc_dec_arbiter #(
        .N(N), .IDW(IDW), .LENW(LENW), .TIMEOUT(TIMEOUT), .FLUSH_CYC(FLUSH_CYC)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference arbitration: first valid requester at or after ptr, wrapping.
    function automatic int rr_pick(input logic [N-1:0] v, input int ptr);
        for (int i = 0; i < N; i++) if (v[(ptr + i) % N]) return (ptr + i) % N;
        return -1;
    endfunction

    function automatic logic [N-1:0] onehot(input int g);
        logic [N-1:0] m;
        m = '0;
        if (g >= 0) m[g] = 1'b1;
        return m;
    endfunction

    task automatic set_req(input int id, input int len);
        words[id] = $urandom;
        bus.req_data[32*id +: 32] = words[id];
        bus.req_len[LENW*id +: LENW] = LENW'(len);
        bus.req_valid[id] = 1'b1;
    endtask

    // Called in IDLE with requests presented; grant edge, len output words, done, flush.
    task automatic drive_job(input int g, input int len, input int stall_at, input int stall_n,
                             input bit clear_valid);
        logic [31:0] w;
        bus.dec_in_ready = 1'b1;
        step();
        vectors++;
        if (bus.req_ready !== onehot(g))
            begin errors++; $display("FAIL grant_ready: got %b want %b", bus.req_ready, onehot(g)); end
        vectors++;
        if (bus.dec_in_data !== words[g] || bus.dec_in_valid !== 1'b1)
            begin errors++; $display("FAIL in_fwd: got %h want %h", bus.dec_in_data, words[g]); end
        for (int k = 0; k < len; k++) begin
            w = $urandom;
            bus.dec_out = w;
            bus.dec_out_valid = 1'b1;
            for (int s = 0; s < ((k == stall_at) ? stall_n : 0); s++) begin
                bus.out_ready = 1'b0;
                #1;
                vectors++;
                if (bus.dec_out_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.req_done !== '0)
                    begin errors++; $display("FAIL stall: got dor=%b ov=%b done=%b want 0 1 0",
                        bus.dec_out_ready, bus.out_valid, bus.req_done); end
                step();
            end
            bus.out_ready = 1'b1;
            #1;
            vectors++;
            if (bus.out_data !== w || bus.out_id !== IDW'(g) || bus.dec_out_ready !== 1'b1
                || bus.req_done !== '0)
                begin errors++; $display("FAIL out_word: got %h id %0d want %h id %0d",
                    bus.out_data, bus.out_id, w, g); end
            step();
        end
        bus.dec_out_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.dec_in_ready = 1'b0;
        if (clear_valid) bus.req_valid = '0;
        #1;
        vectors++;
        if (bus.req_done !== onehot(g) || bus.dec_rst !== 1'b1 || bus.err !== 1'b0)
            begin errors++; $display("FAIL done: got done=%b rst=%b err=%b want %b 1 0",
                bus.req_done, bus.dec_rst, bus.err, onehot(g)); end
        model_rr = (g + 1) % N;
        step();
        vectors++;
        if (bus.req_done !== '0 || bus.dec_rst !== 1'b1)
            begin errors++; $display("FAIL flush2: got done=%b rst=%b want 0 1",
                bus.req_done, bus.dec_rst); end
        step();
        vectors++;
        if (bus.dec_rst !== 1'b0 || bus.busy !== 1'b0)
            begin errors++; $display("FAIL back_idle: got rst=%b busy=%b want 0 0",
                bus.dec_rst, bus.busy); end
    endtask

    task automatic test_reset();
        int n;
        step();
        step();
        vectors++;
        if (bus.dec_rst !== 1'b1 || bus.dec_out_ready !== 1'b1 || bus.busy !== 1'b1)
            begin errors++; $display("FAIL rst_high: got rst=%b dor=%b busy=%b want 1 1 1",
                bus.dec_rst, bus.dec_out_ready, bus.busy); end
        vectors++;
        if (bus.req_ready !== '0 || bus.req_done !== '0 || bus.dec_in_valid !== 1'b0
            || bus.out_valid !== 1'b0 || bus.err !== 1'b0 || bus.err_id !== '0 || bus.out_id !== '0)
            begin errors++; $display("FAIL rst_low: got rdy=%b done=%b div=%b ov=%b err=%b want 0",
                bus.req_ready, bus.req_done, bus.dec_in_valid, bus.out_valid, bus.err); end
        reset_n = 1'b1;
        #1;
        n = 0;
        for (int i = 0; i < 10 && bus.dec_rst === 1'b1; i++) begin
            n++;
            step();
        end
        vectors++;
        if (n !== FLUSH_CYC)
            begin errors++; $display("FAIL flush_len: got %0d want %0d", n, FLUSH_CYC); end
        step();
        vectors++;
        if (bus.busy !== 1'b0 || bus.req_ready !== '0 || bus.out_valid !== 1'b0)
            begin errors++; $display("FAIL idle_after_rst: got busy=%b rdy=%b want 0 0",
                bus.busy, bus.req_ready); end
        model_rr = 0;
    endtask

    task automatic test_round_robin();
        int order[5] = '{0, 1, 2, 3, 0};
        for (int i = 0; i < N; i++) set_req(i, 1);
        for (int j = 0; j < 5; j++) begin
            vectors++;
            if (rr_pick(bus.req_valid, model_rr) !== order[j])
                begin errors++; $display("FAIL rr_model: got %0d want %0d",
                    rr_pick(bus.req_valid, model_rr), order[j]); end
            drive_job(order[j], 1, 0, 0, j == 4);
        end
    endtask

    task automatic test_single_job();
        set_req(2, 3);
        drive_job(rr_pick(bus.req_valid, model_rr), 3, 0, 0, 1'b1);
    endtask

    task automatic test_backpressure();
        set_req(1, 3);
        drive_job(rr_pick(bus.req_valid, model_rr), 3, 1, 5, 1'b1);
    endtask

    task automatic test_zero_len();
        set_req(1, 0);
        bus.dec_in_ready = 1'b1;
        step();
        vectors++;
        if (bus.req_done !== onehot(1) || bus.dec_rst !== 1'b1 || bus.req_ready !== '0
            || bus.busy !== 1'b1)
            begin errors++; $display("FAIL zero_len: got done=%b rst=%b rdy=%b want %b 1 0",
                bus.req_done, bus.dec_rst, bus.req_ready, onehot(1)); end
        model_rr = 2;
        bus.dec_in_ready = 1'b0;
        bus.req_valid = '0;
        set_req(2, 1);
        step();
        step();
        drive_job(rr_pick(bus.req_valid, model_rr), 1, 0, 0, 1'b1);
    endtask

    task automatic test_timeout();
        int g;
        int first;
        bit bad_done;
        set_req(3, 4);
        g = rr_pick(bus.req_valid, model_rr);
        bus.dec_in_ready = 1'b0;
        step();
        for (int k = 0; k < 2; k++) begin
            bus.dec_out = $urandom;
            bus.dec_out_valid = 1'b1;
            bus.out_ready = 1'b1;
            step();
        end
        bus.dec_out_valid = 1'b0;
        bus.out_ready = 1'b0;
        #1;
        first = -1;
        bad_done = 1'b0;
        for (int s = 1; s <= TIMEOUT + 4 && first < 0; s++) begin
            if (bus.req_done !== '0) bad_done = 1'b1;
            if (bus.err === 1'b1) first = s;
            else step();
        end
        vectors++;
        if (first !== TIMEOUT + 1)
            begin errors++; $display("FAIL timeout_cycle: got %0d want %0d", first, TIMEOUT + 1); end
        vectors++;
        if (bus.err_id !== IDW'(g) || bus.dec_rst !== 1'b1 || bad_done)
            begin errors++; $display("FAIL timeout_state: got id=%0d rst=%b bad_done=%b want %0d 1 0",
                bus.err_id, bus.dec_rst, bad_done, g); end
        bus.req_valid = '0;
        model_rr = (g + 1) % N;
        step();
        vectors++;
        if (bus.err !== 1'b0 || bus.err_id !== IDW'(g) || bus.req_done !== '0)
            begin errors++; $display("FAIL err_pulse: got err=%b id=%0d done=%b want 0 %0d 0",
                bus.err, bus.err_id, bus.req_done, g); end
        step();
        vectors++;
        if (bus.busy !== 1'b0)
            begin errors++; $display("FAIL timeout_idle: got busy=%b want 0", bus.busy); end
    endtask

    task automatic test_random();
        logic [N-1:0] mask;
        int lens[N];
        int g;
        for (int it = 0; it < 10; it++) begin
            mask = N'($urandom_range(1, (1 << N) - 1));
            for (int i = 0; i < N; i++) begin
                lens[i] = $urandom_range(1, 4);
                if (mask[i]) set_req(i, lens[i]);
            end
            g = rr_pick(mask, model_rr);
            drive_job(g, lens[g], $urandom_range(0, lens[g] - 1), $urandom_range(0, 3), 1'b1);
        end
    endtask

    task automatic test_reset_midjob();
        set_req(0, 4);
        bus.dec_in_ready = 1'b1;
        step();
        bus.dec_out_valid = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        vectors++;
        if (bus.busy !== 1'b1 || bus.out_valid !== 1'b1)
            begin errors++; $display("FAIL midjob_run: got busy=%b ov=%b want 1 1",
                bus.busy, bus.out_valid); end
        reset_n = 1'b0;
        #1;
        vectors++;
        if (bus.dec_rst !== 1'b1 || bus.req_ready !== '0 || bus.out_valid !== 1'b0
            || bus.req_done !== '0 || bus.err !== 1'b0 || bus.dec_in_valid !== 1'b0)
            begin errors++; $display("FAIL midjob_reset: got rst=%b rdy=%b ov=%b done=%b err=%b",
                bus.dec_rst, bus.req_ready, bus.out_valid, bus.req_done, bus.err); end
        bus.req_valid = '0;
        bus.dec_in_ready = 1'b0;
        bus.dec_out_valid = 1'b0;
        bus.out_ready = 1'b0;
        step();
        reset_n = 1'b1;
        step();
        step();
        step();
        vectors++;
        if (bus.busy !== 1'b0 || bus.req_done !== '0 || bus.err !== 1'b0)
            begin errors++; $display("FAIL post_reset: got busy=%b done=%b err=%b want 0 0 0",
                bus.busy, bus.req_done, bus.err); end
        model_rr = 0;
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_data = '0;
        bus.req_len = '0;
        bus.dec_in_ready = 1'b0;
        bus.dec_out = '0;
        bus.dec_out_valid = 1'b0;
        bus.out_ready = 1'b0;
        test_reset();
        test_round_robin();
        test_single_job();
        test_backpressure();
        test_zero_len();
        test_timeout();
        test_random();
        test_reset_midjob();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
